// File: rtl/tlk2711_mch_tx_cmd.sv
// tlk2711_mch_tx_cmd
// Multi-channel TX read-command generator. Each channel takes a job
// (base address, body length, body count, tail length), which is split into
// DMA read commands. Channels are arbitrated round-robin onto one shared
// rd_cmd port. Only one command is in flight at a time; completion of a
// command is seen on i_dma_rd_last.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   i_soft_rst         synchronous clear, same effect as rst
//   i_tx_start         per-channel job start pulse
//   i_tx_base_addr     per-channel base address (ch0 in LSBs)
//   i_tx_packet_body   per-channel body command length (bytes)
//   i_tx_packet_tail   per-channel tail command length (0 = no tail)
//   i_tx_body_num      per-channel number of body commands
//   o_rd_cmd_req       command request to the DMA
//   i_rd_cmd_ack       DMA accepts the command
//   o_rd_cmd_data      {length, address} of the command
//   i_dma_rd_last      last beat of the in-flight command's read stream
//   o_cmd_ch           channel owning the in-flight command
//   o_ch_busy          channel holds an accepted, unfinished job
//   o_ch_done          one-cycle pulse, job complete
//   o_start_err        one-cycle pulse, start on a busy channel was dropped
//   o_timeout          sticky watchdog flag
//
// Build option: define TLK2711_CMD_TIMEOUT_EN to enable the WAIT watchdog.
// Without it o_timeout is held low and WAIT lasts until i_dma_rd_last.
//
// state  | meaning
// IDLE   | pick next channel with a pending command, load command registers
// REQ    | o_rd_cmd_req high, command held until i_rd_cmd_ack
// WAIT   | command accepted, waiting for i_dma_rd_last (or watchdog)

module tlk2711_mch_tx_cmd #(
   parameter int ADDR_WIDTH     = 48,
   parameter int DLEN_WIDTH     = 16,
   parameter int NUM_CH         = 4,
   parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_soft_rst,
   input  logic [NUM_CH-1:0]                i_tx_start,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]     i_tx_base_addr,
   input  logic [NUM_CH*16-1:0]             i_tx_packet_body,
   input  logic [NUM_CH*16-1:0]             i_tx_packet_tail,
   input  logic [NUM_CH*16-1:0]             i_tx_body_num,
   output logic                             o_rd_cmd_req,
   input  logic                             i_rd_cmd_ack,
   output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
   input  logic                             i_dma_rd_last,
   output logic [CH_W-1:0]                  o_cmd_ch,
   output logic [NUM_CH-1:0]                o_ch_busy,
   output logic [NUM_CH-1:0]                o_ch_done,
   output logic [NUM_CH-1:0]                o_start_err,
   output logic                             o_timeout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] ch_addr      [NUM_CH];
   logic [15:0]           ch_body_len  [NUM_CH];
   logic [15:0]           ch_body_left [NUM_CH];
   logic [15:0]           ch_tail_len  [NUM_CH];
   logic [NUM_CH-1:0]     ch_tail_pend;
   logic [NUM_CH-1:0]     pending;
   logic [CH_W-1:0]       rr_ptr;
   logic [CH_W-1:0]       grant_ch;
   logic [CH_W-1:0]       next_rr;
   logic                  grant_vld;
   logic [15:0]           grant_len;
   logic [15:0]           cmd_len;

`ifdef TLK2711_CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] wd_cnt;
`else
   // TIMEOUT_CYCLES has no effect in this build; the flag is held low.
   assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

   assign o_rd_cmd_req = (state == S_REQ);

   always_comb begin
      pending = '0;
      for (int c = 0; c < NUM_CH; c++)
         pending[c] = o_ch_busy[c] && ((ch_body_left[c] != 16'd0) || ch_tail_pend[c]);
   end

   // Lowest pending channel overall covers the wrap case; the second pass
   // overrides it with the lowest pending channel at or after rr_ptr.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      for (int c = NUM_CH-1; c >= 0; c--) begin
         if (pending[c]) begin
            grant_vld = 1'b1;
            grant_ch  = CH_W'(c);
         end
      end
      for (int c = NUM_CH-1; c >= 0; c--) begin
         if (pending[c] && (CH_W'(c) >= rr_ptr))
            grant_ch = CH_W'(c);
      end
   end

   assign grant_len = (ch_body_left[grant_ch] != 16'd0) ? ch_body_len[grant_ch]
                                                        : ch_tail_len[grant_ch];
   assign next_rr   = (o_cmd_ch == CH_W'(NUM_CH-1)) ? '0 : o_cmd_ch + CH_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         o_cmd_ch      <= '0;
         o_rd_cmd_data <= '0;
         cmd_len       <= '0;
         o_ch_busy     <= '0;
         o_ch_done     <= '0;
         o_start_err   <= '0;
         ch_tail_pend  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            ch_addr[c]      <= '0;
            ch_body_len[c]  <= '0;
            ch_body_left[c] <= '0;
            ch_tail_len[c]  <= '0;
         end
`ifdef TLK2711_CMD_TIMEOUT_EN
         wd_cnt    <= '0;
         o_timeout <= 1'b0;
`endif
      end else if (i_soft_rst) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         o_cmd_ch      <= '0;
         o_rd_cmd_data <= '0;
         cmd_len       <= '0;
         o_ch_busy     <= '0;
         o_ch_done     <= '0;
         o_start_err   <= '0;
         ch_tail_pend  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            ch_addr[c]      <= '0;
            ch_body_len[c]  <= '0;
            ch_body_left[c] <= '0;
            ch_tail_len[c]  <= '0;
         end
`ifdef TLK2711_CMD_TIMEOUT_EN
         wd_cnt    <= '0;
         o_timeout <= 1'b0;
`endif
      end else begin
         o_ch_done   <= '0;
         o_start_err <= '0;

         for (int c = 0; c < NUM_CH; c++) begin
            // Busy with nothing left to issue and nothing in flight: only an
            // empty job reaches this, as in-flight completion is handled in WAIT.
            if (o_ch_busy[c] && !pending[c] &&
                !((state != S_IDLE) && (o_cmd_ch == CH_W'(c)))) begin
               o_ch_busy[c] <= 1'b0;
               o_ch_done[c] <= 1'b1;
            end
            // The done cycle still counts as busy for start acceptance.
            if (i_tx_start[c]) begin
               if (o_ch_busy[c] || o_ch_done[c]) begin
                  o_start_err[c] <= 1'b1;
               end else begin
                  o_ch_busy[c]    <= 1'b1;
                  ch_addr[c]      <= i_tx_base_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                  ch_body_len[c]  <= i_tx_packet_body[c*16 +: 16];
                  ch_body_left[c] <= i_tx_body_num[c*16 +: 16];
                  ch_tail_len[c]  <= i_tx_packet_tail[c*16 +: 16];
                  ch_tail_pend[c] <= (i_tx_packet_tail[c*16 +: 16] != 16'd0);
               end
            end
         end

         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  o_cmd_ch      <= grant_ch;
                  cmd_len       <= grant_len;
                  o_rd_cmd_data <= {DLEN_WIDTH'(grant_len), ch_addr[grant_ch]};
                  state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_rd_cmd_ack) begin
                  ch_addr[o_cmd_ch] <= ch_addr[o_cmd_ch] + ADDR_WIDTH'(cmd_len);
                  if (ch_body_left[o_cmd_ch] != 16'd0)
                     ch_body_left[o_cmd_ch] <= ch_body_left[o_cmd_ch] - 16'd1;
                  else
                     ch_tail_pend[o_cmd_ch] <= 1'b0;
`ifdef TLK2711_CMD_TIMEOUT_EN
                  wd_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_dma_rd_last) begin
                  // Counts were updated at ack, so no pending work means final.
                  if (!pending[o_cmd_ch]) begin
                     o_ch_busy[o_cmd_ch] <= 1'b0;
                     o_ch_done[o_cmd_ch] <= 1'b1;
                  end
                  rr_ptr <= next_rr;
                  state  <= S_IDLE;
               end
`ifdef TLK2711_CMD_TIMEOUT_EN
               else if (wd_cnt == '0) begin
                  o_timeout                 <= 1'b1;
                  o_ch_busy[o_cmd_ch]       <= 1'b0;
                  ch_body_left[o_cmd_ch]    <= '0;
                  ch_tail_pend[o_cmd_ch]    <= 1'b0;
                  rr_ptr                    <= next_rr;
                  state                     <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt - TO_W'(1);
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlk2711_mch_tx_cmd.sv
// Testbench for tlk2711_mch_tx_cmd: single-channel job vectors from a table,
// then hand-written sequences for round-robin, empty job, start error,
// reset during REQ and (when built with TLK2711_CMD_TIMEOUT_EN) the watchdog.

module tb_tlk2711_mch_tx_cmd;

   localparam int AW = 48;
   localparam int DW = 16;
   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          soft_rst = 1'b0;
   logic [NC-1:0] tx_start = '0;
   logic [NC*AW-1:0] tx_base = '0;
   logic [NC*16-1:0] tx_body = '0;
   logic [NC*16-1:0] tx_tail = '0;
   logic [NC*16-1:0] tx_num  = '0;
   logic          req;
   logic          ack = 1'b0;
   logic [DW+AW-1:0] data;
   logic          rd_last = 1'b0;
   logic [1:0]    cmd_ch;
   logic [NC-1:0] busy, done, start_err;
   logic          timeout;

   int n_chk  = 0;
   int n_fail = 0;

   tlk2711_mch_tx_cmd #(
      .ADDR_WIDTH(AW), .DLEN_WIDTH(DW), .NUM_CH(NC), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .i_soft_rst(soft_rst),
      .i_tx_start(tx_start), .i_tx_base_addr(tx_base),
      .i_tx_packet_body(tx_body), .i_tx_packet_tail(tx_tail),
      .i_tx_body_num(tx_num),
      .o_rd_cmd_req(req), .i_rd_cmd_ack(ack), .o_rd_cmd_data(data),
      .i_dma_rd_last(rd_last), .o_cmd_ch(cmd_ch),
      .o_ch_busy(busy), .o_ch_done(done), .o_start_err(start_err),
      .o_timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   typedef struct {
      int          ch;
      logic [47:0] base;
      logic [15:0] body;
      logic [15:0] num;
      logic [15:0] tail;
      int          ncmd;
      logic [63:0] first;
      logic [63:0] last;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_job(input int ch, input logic [47:0] base, input logic [15:0] body,
                          input logic [15:0] num, input logic [15:0] tail);
      tx_base[ch*AW +: AW] = base;
      tx_body[ch*16 +: 16] = body;
      tx_num[ch*16 +: 16]  = num;
      tx_tail[ch*16 +: 16] = tail;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!req && n < 50) begin
         tick();
         n++;
      end
      chk({name, " req"}, 64'(req), 64'd1);
   endtask

   // Service one command: check it, hold ack off one cycle, accept, then
   // finish the read stream two cycles later.
   task automatic serve(input int ch, input logic [63:0] exp, input bit fin, input string name);
      wait_req(name);
      chk({name, " data"}, data, exp);
      chk({name, " ch"}, 64'(cmd_ch), 64'(ch));
      tick();
      chk({name, " hold"}, {63'd0, req} | (data ^ exp), 64'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk({name, " req drop"}, 64'(req), 64'd0);
      tick();
      tick();
      rd_last = 1'b1;
      tick();
      rd_last = 1'b0;
      chk({name, " done"}, 64'(done[ch]), 64'(fin));
      chk({name, " busy"}, 64'(busy[ch]), 64'(!fin));
   endtask

   initial begin
      logic [47:0] addr;
      logic [15:0] len;
      logic [63:0] exp;
      int n;

      vecs[0] = '{0, 48'h1000, 16'h400, 16'd3, 16'h100, 4,
                  {16'h0400, 48'h1000}, {16'h0100, 48'h1C00}};
      vecs[1] = '{3, 48'hFFFF_FFFF_FF00, 16'h100, 16'd2, 16'h0, 2,
                  {16'h0100, 48'hFFFF_FFFF_FF00}, {16'h0100, 48'h0}};
      vecs[2] = '{1, 48'h2000, 16'h0, 16'd0, 16'h40, 1,
                  {16'h0040, 48'h2000}, {16'h0040, 48'h2000}};
      vecs[3] = '{2, 48'h10, 16'h10, 16'd1, 16'h8, 2,
                  {16'h0010, 48'h10}, {16'h0008, 48'h20}};
      vecs[4] = '{1, 48'h0, 16'hFFFF, 16'd2, 16'h1, 3,
                  {16'hFFFF, 48'h0}, {16'h0001, 48'h1_FFFE}};

      // reset state
      tick();
      tick();
      chk("rst req", 64'(req), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst data", data, 64'd0);
      rst = 1'b0;
      tick();

      // single-channel job table
      for (int v = 0; v < 5; v++) begin
         set_job(vecs[v].ch, vecs[v].base, vecs[v].body, vecs[v].num, vecs[v].tail);
         tx_start[vecs[v].ch] = 1'b1;
         tick();
         tx_start = '0;
         chk($sformatf("v%0d busy", v), 64'(busy[vecs[v].ch]), 64'd1);
         addr = vecs[v].base;
         for (int k = 0; k < vecs[v].ncmd; k++) begin
            len = (k < int'(vecs[v].num)) ? vecs[v].body : vecs[v].tail;
            exp = (k == 0) ? vecs[v].first :
                  (k == vecs[v].ncmd - 1) ? vecs[v].last : {len, addr};
            serve(vecs[v].ch, exp, k == vecs[v].ncmd - 1, $sformatf("v%0d c%0d", v, k));
            addr = addr + 48'(len);
         end
         tick();
         chk($sformatf("v%0d done pulse", v), 64'(done), 64'd0);
      end

      // soft reset, then all four channels started together
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      chk("soft rst busy", 64'(busy), 64'd0);
      chk("soft rst ch", 64'(cmd_ch), 64'd0);
      for (int c = 0; c < NC; c++) set_job(c, 48'(c * 32'h1000), 16'h80, 16'd2, 16'h0);
      tx_start = 4'hF;
      tick();
      tx_start = '0;
      chk("rr busy", 64'(busy), 64'hF);
      for (int k = 0; k < 8; k++) begin
         exp = {16'h0080, 48'((k % 4) * 32'h1000 + (k / 4) * 32'h80)};
         serve(k % 4, exp, k >= 4, $sformatf("rr g%0d", k));
      end
      chk("rr all idle", 64'(busy), 64'd0);

      // empty job on ch2
      set_job(2, 48'h1234, 16'h0, 16'd0, 16'h0);
      tx_start[2] = 1'b1;
      tick();
      tx_start = '0;
      chk("empty busy", 64'(busy[2]), 64'd1);
      chk("empty done early", 64'(done[2]), 64'd0);
      tick();
      chk("empty done", 64'(done[2]), 64'd1);
      chk("empty busy clr", 64'(busy[2]), 64'd0);
      chk("empty no req", 64'(req), 64'd0);
      tick();
      chk("empty done once", 64'(done[2]), 64'd0);

      // restart while busy, and start during the done cycle
      set_job(1, 48'h500, 16'h20, 16'd1, 16'h0);
      tx_start[1] = 1'b1;
      tick();
      tx_start = '0;
      wait_req("serr");
      set_job(1, 48'h9999, 16'h30, 16'd4, 16'h0);
      tx_start[1] = 1'b1;
      tick();
      tx_start = '0;
      chk("serr pulse", 64'(start_err), 64'b0010);
      tick();
      chk("serr clear", 64'(start_err), 64'd0);
      serve(1, {16'h0020, 48'h500}, 1'b1, "serr cmd");
      tx_start[1] = 1'b1;
      tick();
      tx_start = '0;
      chk("serr on done", 64'(start_err[1]), 64'd1);
      chk("serr on done busy", 64'(busy[1]), 64'd0);
      tick();
      tick();
      chk("serr no req", 64'(req), 64'd0);

      // async reset during REQ
      set_job(1, 48'h3000, 16'h40, 16'd2, 16'h0);
      tx_start[1] = 1'b1;
      tick();
      tx_start = '0;
      wait_req("arst");
      rst = 1'b1;
      #1;
      chk("arst req", 64'(req), 64'd0);
      chk("arst busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      rd_last = 1'b1;
      ack = 1'b1;
      tick();
      rd_last = 1'b0;
      ack = 1'b0;
      chk("arst late last", 64'(done), 64'd0);
      chk("arst idle", 64'(req), 64'd0);
      set_job(1, 48'h4000, 16'h10, 16'd1, 16'h0);
      tx_start[1] = 1'b1;
      tick();
      tx_start = '0;
      serve(1, {16'h0010, 48'h4000}, 1'b1, "arst new");

`ifdef TLK2711_CMD_TIMEOUT_EN
      // watchdog: rr_ptr is 2 here, so ch0 is granted first
      set_job(0, 48'hA000, 16'h10, 16'd1, 16'h0);
      set_job(1, 48'hB000, 16'h20, 16'd1, 16'h0);
      tx_start = 4'b0011;
      tick();
      tx_start = '0;
      wait_req("wd");
      chk("wd ch", 64'(cmd_ch), 64'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n = 0;
      while (!timeout && n < 40) begin
         tick();
         n++;
      end
      chk("wd cycles", 64'(n), 64'd16);
      chk("wd busy0", 64'(busy[0]), 64'd0);
      chk("wd no done", 64'(done[0]), 64'd0);
      serve(1, {16'h0020, 48'hB000}, 1'b1, "wd next");
      chk("wd sticky", 64'(timeout), 64'd1);
`else
      n = 0;
      chk("no wd flag", 64'(timeout), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
